// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch FSM with prefetch FIFO
module fetch_unit #(
   parameter int ADDR_W  = 32,
   parameter int INSTR_W = 32,
   parameter int DEPTH   = 4
) (
   input  logic               iCLK,
   input  logic               iRST,
   input  logic [ADDR_W-1:0]  iInitialPC,
   input  logic               iRedirect,
   input  logic [ADDR_W-1:0]  iTarget,
   output logic               oIReadEnable,
   output logic [ADDR_W-1:0]  oIAddress,
   input  logic [INSTR_W-1:0] iIReadData,
   input  logic               iIReadValid,
   output logic [INSTR_W-1:0] oInstr,
   output logic [ADDR_W-1:0]  oInstrPC,
   output logic               oValid,
   input  logic               iReady,
   output logic [4:0]         oCount
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

   typedef enum logic [1:0] {REQ, WAIT, DROP} fetchState_t;

   fetchState_t          state, nextState;
   logic [ADDR_W-1:0]    fetchPc;
   logic [ADDR_W-1:0]    reqAddr;
   logic [INSTR_W-1:0]   instrMem [DEPTH];
   logic [ADDR_W-1:0]    pcMem    [DEPTH];
   logic [PTR_W-1:0]     rdPtr, wrPtr;
   logic [4:0]           count;
   logic                 issue, push, pop;

   function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) state <= REQ;
      else      state <= nextState;
   end

   always_comb begin
      nextState = state;
      case (state)
         REQ:     if (issue) nextState = WAIT;
         WAIT: begin
            if (iIReadValid)    nextState = REQ;
            else if (iRedirect) nextState = DROP;
         end
         DROP:    if (iIReadValid) nextState = REQ;
         default: nextState = REQ;
      endcase
   end

   // The request slot is reserved at issue, so the later push cannot overflow.
   always_comb begin
      issue     = 1'b0;
      push      = 1'b0;
      oIAddress = reqAddr;
      case (state)
         REQ: begin
            issue     = !iRST && !iRedirect && (count < 5'(DEPTH));
            oIAddress = fetchPc;
         end
         WAIT:    push = iIReadValid && !iRedirect;
         default: ;
      endcase
      oIReadEnable = issue;
   end

   assign pop = (count != 5'd0) && iReady && !iRedirect;

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         fetchPc <= iInitialPC & ALIGN_MASK;
         reqAddr <= iInitialPC & ALIGN_MASK;
         rdPtr   <= '0;
         wrPtr   <= '0;
         count   <= 5'd0;
      end else begin
         if (issue) reqAddr <= fetchPc;
         if (iRedirect)  fetchPc <= iTarget & ALIGN_MASK;
         else if (push)  fetchPc <= fetchPc + ADDR_W'(4);
         if (iRedirect) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= 5'd0;
         end else begin
            if (push) wrPtr <= nextPtr(wrPtr);
            if (pop)  rdPtr <= nextPtr(rdPtr);
            if (push && !pop)      count <= count + 5'd1;
            else if (!push && pop) count <= count - 5'd1;
         end
      end
   end

   always_ff @(posedge iCLK) begin
      if (push) begin
         instrMem[wrPtr] <= iIReadData;
         pcMem[wrPtr]    <= reqAddr;
      end
   end

   assign oInstr   = instrMem[rdPtr];
   assign oInstrPC = pcMem[rdPtr];
   assign oValid   = (count != 5'd0);
   assign oCount   = count;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;
   localparam int DEPTH = 4;

   logic        iCLK = 1'b0;
   logic        iRST = 1'b0;
   logic [31:0] iInitialPC = '0;
   logic        iRedirect = 1'b0;
   logic [31:0] iTarget = '0;
   logic        oIReadEnable;
   logic [31:0] oIAddress;
   logic [31:0] iIReadData = '0;
   logic        iIReadValid = 1'b0;
   logic [31:0] oInstr;
   logic [31:0] oInstrPC;
   logic        oValid;
   logic        iReady = 1'b0;
   logic [4:0]  oCount;

   fetch_unit dut (
      .iCLK(iCLK), .iRST(iRST), .iInitialPC(iInitialPC),
      .iRedirect(iRedirect), .iTarget(iTarget),
      .oIReadEnable(oIReadEnable), .oIAddress(oIAddress),
      .iIReadData(iIReadData), .iIReadValid(iIReadValid),
      .oInstr(oInstr), .oInstrPC(oInstrPC), .oValid(oValid),
      .iReady(iReady), .oCount(oCount)
   );

   always #5 iCLK = ~iCLK;

   int nTests = 0;
   int nFail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      nTests++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] instrOf(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A3C, a[31:16] ^ 16'hC0DE};
   endfunction

   // Reference model: an in-order queue of fetched words plus one outstanding request.
   typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
   ent_t        mq[$];
   logic [31:0] mPc, mReqAddr;
   bit          mOut, mStale;

   // Bus responder
   bit          busPending;
   int          busCnt, busLat;
   logic [31:0] busAddr;

   // Samples of DUT outputs in the current cycle
   logic        sEn, sValid;
   logic [31:0] sAddr, sPc, sInstr;
   logic [4:0]  sCount;

   task automatic doReset(input logic [31:0] pc);
      iInitialPC = pc; iRedirect = 0; iIReadValid = 0; iReady = 0; iTarget = 0;
      iRST = 1;
      #1;
      check("rst_count", oCount, 0);
      check("rst_valid", oValid, 0);
      check("rst_en", oIReadEnable, 0);
      check("rst_addr", oIAddress, pc & ~32'd3);
      @(negedge iCLK); @(negedge iCLK);
      iRST = 0;
      mq.delete(); mPc = pc & ~32'd3; mReqAddr = mPc; mOut = 0; mStale = 0;
      busPending = 0;
   endtask

   // One clock cycle, entered and left at a falling edge.
   task automatic step(input logic rd, input logic [31:0] tg, input logic rdy, input logic stray);
      bit expEn, resp;
      iRedirect = rd; iTarget = tg; iReady = rdy;
      if (busPending) busCnt--;
      iIReadValid = (busPending && busCnt == 0) || stray;
      iIReadData  = (busPending && busCnt == 0) ? instrOf(busAddr) : $urandom;
      #1;
      sEn = oIReadEnable; sAddr = oIAddress; sValid = oValid;
      sPc = oInstrPC; sInstr = oInstr; sCount = oCount;

      expEn = !mOut && mq.size() < DEPTH && !rd;
      check("en", sEn, expEn);
      check("count", sCount, mq.size());
      check("valid", sValid, mq.size() != 0);
      if (mq.size() != 0) begin
         check("headPc", sPc, mq[0].pc);
         check("headInstr", sInstr, mq[0].instr);
      end
      if (expEn)     check("issueAddr", sAddr, mPc);
      else if (mOut) check("holdAddr", sAddr, mReqAddr);

      resp = mOut && iIReadValid;
      if (rd) begin
         mq.delete();
         mPc = tg & ~32'd3;
         if (resp) begin mOut = 0; mStale = 0; end
         else if (mOut) mStale = 1;
      end else begin
         if (mq.size() != 0 && rdy) void'(mq.pop_front());
         if (resp) begin
            if (!mStale) begin
               mq.push_back('{mReqAddr, instrOf(mReqAddr)});
               mPc = mPc + 32'd4;
            end
            mOut = 0; mStale = 0;
         end
      end
      if (expEn) begin mOut = 1; mStale = 0; mReqAddr = mPc; end

      if (busPending && busCnt == 0) busPending = 0;
      if (sEn) begin
         busPending = 1;
         busAddr    = sAddr;
         busCnt     = (busLat == 0) ? int'($urandom_range(1, 3)) : busLat;
      end
      @(negedge iCLK);
   endtask

   typedef struct {
      logic rd; logic [31:0] tg; logic rdy; logic vld; logic [31:0] dataPc;
      logic en; logic [31:0] addr; logic ov; logic [31:0] opc; logic [4:0] cnt;
   } vec_t;

   function automatic vec_t mk(input logic rd, input logic [31:0] tg, input logic vld,
                               input logic [31:0] dataPc, input logic en, input logic [31:0] addr,
                               input logic ov, input logic [31:0] opc, input logic [4:0] cnt);
      vec_t v;
      v.rd = rd; v.tg = tg; v.rdy = 1'b1; v.vld = vld; v.dataPc = dataPc;
      v.en = en; v.addr = addr; v.ov = ov; v.opc = opc; v.cnt = cnt;
      return v;
   endfunction

   vec_t vecs[11];
   int   readyPct[3] = '{20, 60, 95};

   initial begin
      // 1-cycle latency, iReady=1, with a redirect coincident with a response
      vecs[0]  = mk(0, 0,          0, 0,          1, 32'h00400000, 0, 0,            0);
      vecs[1]  = mk(0, 0,          1, 32'h00400000, 0, 32'h00400000, 0, 0,          0);
      vecs[2]  = mk(0, 0,          0, 0,          1, 32'h00400004, 1, 32'h00400000, 1);
      vecs[3]  = mk(0, 0,          1, 32'h00400004, 0, 32'h00400004, 0, 0,          0);
      vecs[4]  = mk(0, 0,          0, 0,          1, 32'h00400008, 1, 32'h00400004, 1);
      vecs[5]  = mk(0, 0,          1, 32'h00400008, 0, 32'h00400008, 0, 0,          0);
      vecs[6]  = mk(0, 0,          0, 0,          1, 32'h0040000C, 1, 32'h00400008, 1);
      vecs[7]  = mk(1, 32'h00400203, 1, 32'h0040000C, 0, 32'h0040000C, 0, 0,        0);
      vecs[8]  = mk(0, 0,          0, 0,          1, 32'h00400200, 0, 0,            0);
      vecs[9]  = mk(0, 0,          1, 32'h00400200, 0, 32'h00400200, 0, 0,          0);
      vecs[10] = mk(0, 0,          0, 0,          1, 32'h00400204, 1, 32'h00400200, 1);

      #2;
      doReset(32'h00400000);
      for (int i = 0; i < 11; i++) begin
         iRedirect = vecs[i].rd; iTarget = vecs[i].tg; iReady = vecs[i].rdy;
         iIReadValid = vecs[i].vld; iIReadData = instrOf(vecs[i].dataPc);
         #1;
         check($sformatf("vec%0d_en", i), oIReadEnable, vecs[i].en);
         check($sformatf("vec%0d_addr", i), oIAddress, vecs[i].addr);
         check($sformatf("vec%0d_valid", i), oValid, vecs[i].ov);
         check($sformatf("vec%0d_count", i), oCount, vecs[i].cnt);
         if (vecs[i].ov) begin
            check($sformatf("vec%0d_pc", i), oInstrPC, vecs[i].opc);
            check($sformatf("vec%0d_instr", i), oInstr, instrOf(vecs[i].opc));
         end
         @(negedge iCLK);
      end

      // Buffer fills to DEPTH with consumer stalled, then one pop frees one request
      busLat = 1;
      doReset(32'h00001003);
      repeat (10) step(0, 0, 0, 0);
      check("full_count", sCount, 4);
      check("full_en", sEn, 0);
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);
      check("afterpop_count", sCount, 3);
      check("afterpop_en", sEn, 1);
      check("afterpop_addr", sAddr, 32'h00001010);

      // Redirect while waiting; late response dropped
      busLat = 4;
      doReset(32'h00400000);
      step(0, 0, 1, 0);
      step(1, 32'h00400100, 1, 0);
      step(0, 0, 1, 0);
      check("drop_en", sEn, 0);
      step(0, 0, 1, 0);
      step(0, 0, 1, 0);
      step(0, 0, 1, 0);
      check("drop_count", sCount, 0);
      check("drop_en_after", sEn, 1);
      check("drop_addr", sAddr, 32'h00400100);

      // PC wraps at the top of the address space
      busLat = 1;
      doReset(32'hFFFFFFFC);
      step(0, 0, 1, 0);
      check("wrap_first", sAddr, 32'hFFFFFFFC);
      step(0, 0, 1, 0);
      step(0, 0, 1, 0);
      check("wrap_en", sEn, 1);
      check("wrap_addr", sAddr, 32'h00000000);

      // Reset mid-transaction with 2 buffered entries, then a stray response
      doReset(32'h00002000);
      repeat (5) step(0, 0, 0, 0);
      check("pre_rst_count", sCount, 2);
      doReset(32'h00003000);
      step(0, 0, 0, 1);
      check("post_rst_en", sEn, 1);
      check("post_rst_count", sCount, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      check("post_rst_push", sCount, 1);
      check("post_rst_pc", sPc, 32'h00003000);

      // Randomized traffic against the reference model
      busLat = 0;
      for (int r = 0; r < 3; r++) begin
         doReset($urandom);
         for (int c = 0; c < 500; c++)
            step($urandom_range(0, 99) < 6, $urandom, $urandom_range(0, 99) < readyPct[r], 0);
      end

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end
endmodule
